knn_idx_pack: RTL and testbench

KNN_IDX_PACK -- requirements
Module: knn_idx_pack

---
 rtl/knn_idx_pack_pkg.sv | 29 ++
 rtl/knn_idx_lane_buf.sv | 51 +++++
 rtl/knn_idx_pack.sv | 183 ++++++++++++++++++
 tb/tb_knn_idx_pack.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/knn_idx_pack_pkg.sv
// Shared definitions for the KNN index packer: FSM state encoding, default
// widths of the coordinate/sorting path and the lanes-per-word helpers.
package knn_idx_pack_pkg;

  localparam int SRAM_WIDTH_DEF = 256;
  localparam int IDX_WIDTH_DEF  = 10;
  localparam int K_WIDTH_DEF    = 5;
  localparam int ADDR_WIDTH_DEF = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Number of whole indices that fit in one GLB word.
  function automatic int calc_npw(input int sram_w, input int idx_w);
    return sram_w / idx_w;
  endfunction

  // Width of a lane counter able to hold 0..npw-1.
  function automatic int lane_bits(input int npw);
    return (npw > 1) ? $clog2(npw) : 1;
  endfunction

  localparam int NPW_DEF = calc_npw(SRAM_WIDTH_DEF, IDX_WIDTH_DEF);

endpackage

// File: rtl/knn_idx_lane_buf.sv
// Lane-indexed pack register: collects indices into one GLB word, lane 0 in
// the LSBs. o_word_ins is the word with the current index merged in, so the
// owner can capture a completing word in the same cycle the last lane fills.
module knn_idx_lane_buf
  import knn_idx_pack_pkg::*;
#(
  parameter int SRAM_WIDTH = SRAM_WIDTH_DEF,
  parameter int IDX_WIDTH  = IDX_WIDTH_DEF,
  parameter int NPW        = calc_npw(SRAM_WIDTH, IDX_WIDTH),
  parameter int LW         = lane_bits(NPW)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_clr,
  input  logic                  i_push,
  input  logic [IDX_WIDTH-1:0]  i_idx,
  output logic [SRAM_WIDTH-1:0] o_word,
  output logic [SRAM_WIDTH-1:0] o_word_ins,
  output logic                  o_full
);

  logic [SRAM_WIDTH-1:0] r_word;
  logic [LW-1:0]         r_lane;

  assign o_word     = r_word;
  assign o_full     = (r_lane == LW'(NPW - 1));
  assign o_word_ins = r_word | (SRAM_WIDTH'(i_idx) << (int'(r_lane) * IDX_WIDTH));

  // Store the pushed index at the current lane; a push into the last lane
  // hands the word off, so the register and lane restart from zero.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  // NOTE: the pack register takes the async reset too; unfilled lanes must read as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word <= '0;
      r_lane <= '0;
    end else if (i_clr) begin
      r_word <= '0;
      r_lane <= '0;
    end else if (i_push) begin
      if (o_full) begin
        r_word <= '0;
        r_lane <= '0;
      end else begin
        r_word <= o_word_ins;
        r_lane <= r_lane + 1'b1;
      end
    end
  end

endmodule

// File: rtl/knn_idx_pack.sv
// KNN neighbour-index packer: takes the sorted neighbour index stream, packs
// floor(SRAM_WIDTH/IDX_WIDTH) indices per GLB word and writes the words to
// consecutive addresses starting at cfg_base, then pulses done.
// Optional build macro KNN_IDX_PACK_SELF_EXCL_EN: drop the k==0 (self match)
// index of every point, so only cfg_k-1 neighbours per point are stored.
module knn_idx_pack
  import knn_idx_pack_pkg::*;
#(
  parameter int SRAM_WIDTH = SRAM_WIDTH_DEF,
  parameter int IDX_WIDTH  = IDX_WIDTH_DEF,
  parameter int K_WIDTH    = K_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  cfg_vld,
  output logic                  cfg_rdy,
  input  logic [IDX_WIDTH-1:0]  cfg_nop,
  input  logic [K_WIDTH-1:0]    cfg_k,
  input  logic [ADDR_WIDTH-1:0] cfg_base,
  input  logic [IDX_WIDTH-1:0]  in_idx,
  input  logic                  in_vld,
  output logic                  in_rdy,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [SRAM_WIDTH-1:0] wr_dat,
  output logic                  wr_vld,
  input  logic                  wr_rdy,
  output logic                  done
);

  localparam int NPW = calc_npw(SRAM_WIDTH, IDX_WIDTH);
  localparam int LW  = lane_bits(NPW);

  state_e                r_state;
  logic                  r_done;
  logic [IDX_WIDTH-1:0]  r_nop;
  logic [IDX_WIDTH-1:0]  r_pt;
  logic [K_WIDTH-1:0]    r_kcfg;
  logic [K_WIDTH-1:0]    r_k;
  logic                  r_wr_vld;
  logic [SRAM_WIDTH-1:0] r_wr_dat;
  logic [ADDR_WIDTH-1:0] r_wr_addr;

  logic                  w_cfg_hs;
  logic                  w_cfg_zero;
  logic                  w_in_hs;
  logic                  w_store;
  logic                  w_out_free;
  logic                  w_k_last;
  logic                  w_last;
  logic                  w_full;
  logic                  w_run_load;
  logic                  w_flush_load;
  logic                  w_load;
  logic                  w_buf_clr;
  logic [SRAM_WIDTH-1:0] w_word;
  logic [SRAM_WIDTH-1:0] w_word_ins;

  assign cfg_rdy = (r_state == ST_IDLE);
  assign w_cfg_hs = cfg_vld & cfg_rdy;

  // The output register can take a new word when empty or being drained now.
  assign w_out_free = ~r_wr_vld | wr_rdy;
  assign in_rdy     = (r_state == ST_RUN) & (~w_full | w_out_free);
  assign w_in_hs    = in_vld & in_rdy;

`ifdef KNN_IDX_PACK_SELF_EXCL_EN
  assign w_cfg_zero = (cfg_nop == '0) | (cfg_k <= K_WIDTH'(1));
  assign w_store    = w_in_hs & (r_k != '0);
`else
  assign w_cfg_zero = (cfg_nop == '0) | (cfg_k == '0);
  assign w_store    = w_in_hs;
`endif

  assign w_k_last     = (r_k == r_kcfg - K_WIDTH'(1));
  assign w_last       = w_k_last & (r_pt == r_nop - IDX_WIDTH'(1));
  assign w_run_load   = w_store & w_full;
  assign w_flush_load = (r_state == ST_FLUSH) & w_out_free;
  assign w_load       = w_run_load | w_flush_load;
  assign w_buf_clr    = clr | w_flush_load;

  knn_idx_lane_buf #(
    .SRAM_WIDTH (SRAM_WIDTH),
    .IDX_WIDTH  (IDX_WIDTH),
    .NPW        (NPW),
    .LW         (LW)
  ) u_lane_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (w_buf_clr),
    .i_push     (w_store),
    .i_idx      (in_idx),
    .o_word     (w_word),
    .o_word_ins (w_word_ins),
    .o_full     (w_full)
  );

  // Job sequencing; done is raised as the last write drains, so it appears
  // in the first cycle with wr_vld low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (clr) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE:  if (w_cfg_hs) r_state <= w_cfg_zero ? ST_DONE : ST_RUN;
          ST_RUN:   if (w_in_hs && w_last) r_state <= w_run_load ? ST_DONE : ST_FLUSH;
          ST_FLUSH: if (w_out_free) r_state <= ST_DONE;
          ST_DONE: begin
            if (w_out_free) begin
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end
          end
          default:  r_state <= ST_IDLE;
        endcase
      end
    end
  end

  // Job configuration and the k / point counters that locate the last index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_nop  <= '0;
      r_kcfg <= '0;
      r_pt   <= '0;
      r_k    <= '0;
    end else if (clr) begin
      r_nop  <= '0;
      r_kcfg <= '0;
      r_pt   <= '0;
      r_k    <= '0;
    end else if (w_cfg_hs) begin
      r_nop  <= cfg_nop;
      r_kcfg <= cfg_k;
      r_pt   <= '0;
      r_k    <= '0;
    end else if (w_in_hs) begin
      if (w_k_last) begin
        r_k  <= '0;
        r_pt <= r_pt + 1'b1;
      end else begin
        r_k  <= r_k + 1'b1;
      end
    end
  end

  // Single-entry output register; the address advances on each accepted write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_vld  <= 1'b0;
      r_wr_dat  <= '0;
      r_wr_addr <= '0;
    end else if (clr) begin
      r_wr_vld  <= 1'b0;
      r_wr_dat  <= '0;
      r_wr_addr <= '0;
    end else begin
      if (w_cfg_hs) begin
        r_wr_addr <= cfg_base;
      end else if (r_wr_vld && wr_rdy) begin
        r_wr_addr <= r_wr_addr + 1'b1;
      end
      if (w_load) begin
        r_wr_vld <= 1'b1;
        r_wr_dat <= w_run_load ? w_word_ins : w_word;
      end else if (wr_rdy) begin
        r_wr_vld <= 1'b0;
      end
    end
  end

  assign wr_vld  = r_wr_vld;
  assign wr_dat  = r_wr_dat;
  assign wr_addr = r_wr_addr;
  assign done    = r_done;

endmodule

// File: tb/tb_knn_idx_pack.sv
// Self-checking bench for knn_idx_pack: directed job table plus random index
// data and random write backpressure, checked against a queue-based packing
// model of the expected GLB words.
module tb_knn_idx_pack;

  localparam int SW  = 256;
  localparam int IW  = 10;
  localparam int KW  = 5;
  localparam int AW  = 10;
  localparam int NPW = SW / IW;

`ifdef KNN_IDX_PACK_SELF_EXCL_EN
  localparam bit SELF_EXCL = 1'b1;
`else
  localparam bit SELF_EXCL = 1'b0;
`endif

  typedef struct {
    int nop;
    int k;
    int base;
    int rdy_mode;   // 0 always ready, 1 random, 2 stall after first word, 3 rarely ready
    int stall;
    int exp_writes;
    int exp_gap;    // cycles from last write to done, 0 = not checked
  } vec_t;

  logic          clk, rst_n, clr;
  logic          cfg_vld, cfg_rdy;
  logic [IW-1:0] cfg_nop;
  logic [KW-1:0] cfg_k;
  logic [AW-1:0] cfg_base;
  logic [IW-1:0] in_idx;
  logic          in_vld, in_rdy;
  logic [AW-1:0] wr_addr;
  logic [SW-1:0] wr_dat;
  logic          wr_vld, wr_rdy;
  logic          done;

  int n_pass = 0;
  int n_total = 0;

  int rdy_mode = 0;
  int stall_left = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int last_wr_cyc = 0;
  int proto_err = 0;
  int inrdy_err = 0;
  bit stuck = 0;
  logic [AW-1:0] got_addr[$];
  logic [SW-1:0] got_dat[$];

  knn_idx_pack #(
    .SRAM_WIDTH(SW), .IDX_WIDTH(IW), .K_WIDTH(KW), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .cfg_vld(cfg_vld), .cfg_rdy(cfg_rdy), .cfg_nop(cfg_nop), .cfg_k(cfg_k), .cfg_base(cfg_base),
    .in_idx(in_idx), .in_vld(in_vld), .in_rdy(in_rdy),
    .wr_addr(wr_addr), .wr_dat(wr_dat), .wr_vld(wr_vld), .wr_rdy(wr_rdy),
    .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [SW-1:0] got, input logic [SW-1:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Write-side ready pattern, changed just after each rising edge.
  initial begin
    wr_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1: wr_rdy = ($urandom_range(0, 3) != 0);
        2: begin
          if (stall_left > 0 && wr_vld) begin
            wr_rdy = 1'b0;
            stall_left--;
          end else begin
            wr_rdy = 1'b1;
          end
        end
        3: wr_rdy = ($urandom_range(0, 31) == 0);
        default: wr_rdy = 1'b1;
      endcase
    end
  end

  // Monitor at the falling edge: writes, done pulses and protocol rules.
  initial begin
    logic          p_vld, p_rdy;
    logic [SW-1:0] p_dat;
    logic [AW-1:0] p_addr;
    p_vld = 1'b0; p_rdy = 1'b0; p_dat = '0; p_addr = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) begin
        if (wr_vld && wr_rdy) begin
          got_addr.push_back(wr_addr);
          got_dat.push_back(wr_dat);
          last_wr_cyc = cyc;
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
          if (wr_vld) proto_err++;
        end
        if (in_vld && !in_rdy && !(wr_vld && !wr_rdy)) inrdy_err++;
        if (p_vld && !p_rdy && !(wr_vld && wr_dat == p_dat && wr_addr == p_addr)) proto_err++;
        p_vld = wr_vld; p_rdy = wr_rdy; p_dat = wr_dat; p_addr = wr_addr;
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Entered just after a rising edge; returns just after a rising edge.
  task automatic do_cfg(input int nop, input int k, input int base);
    int guard;
    cfg_nop = IW'(nop); cfg_k = KW'(k); cfg_base = AW'(base); cfg_vld = 1'b1;
    guard = 0;
    @(negedge clk);
    while (!cfg_rdy && guard < 100) begin guard++; @(negedge clk); end
    if (!cfg_rdy) check("cfg_timeout", 0, 1);
    @(posedge clk);
    #1;
    cfg_vld = 1'b0;
  endtask

  task automatic send_idx(input logic [IW-1:0] v, input bit gaps);
    int guard;
    if (stuck) return;
    if (gaps && $urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    in_idx = v; in_vld = 1'b1; guard = 0;
    @(negedge clk);
    while (!in_rdy && guard < 600) begin guard++; @(negedge clk); end
    if (!in_rdy) begin
      check("in_accept_timeout", 0, 1);
      stuck = 1'b1;
    end
    @(posedge clk);
    #1;
    in_vld = 1'b0;
  endtask

  task automatic run_vec(input int n, input vec_t v);
    logic [IW-1:0] sent[$];
    logic [IW-1:0] stored[$];
    logic [SW-1:0] exp_w[$];
    logic [SW-1:0] cur;
    logic [IW-1:0] val;
    int keff, nst, d0, guard, nchk;
    string tag;
    tag = $sformatf("v%0d", n);
    @(posedge clk);
    #1;
    got_addr.delete(); got_dat.delete();
    proto_err = 0; inrdy_err = 0;
    rdy_mode = v.rdy_mode; stall_left = v.stall;
    d0 = done_cnt;
    // Reference: the stream of indices, the stored subset, chunked NPW per word.
    keff = SELF_EXCL ? v.k - 1 : v.k;
    if (v.nop > 0 && keff > 0) begin
      for (int p = 0; p < v.nop; p++) begin
        for (int k = 0; k < v.k; k++) begin
          val = IW'($urandom_range(0, (1 << IW) - 1));
          sent.push_back(val);
          if (!(SELF_EXCL && k == 0)) stored.push_back(val);
        end
      end
    end
    cur = '0; nst = 0;
    foreach (stored[i]) begin
      cur[(nst % NPW) * IW +: IW] = stored[i];
      nst++;
      if (nst % NPW == 0) begin exp_w.push_back(cur); cur = '0; end
    end
    if (nst % NPW != 0) exp_w.push_back(cur);

    do_cfg(v.nop, v.k, v.base);
    foreach (sent[i]) send_idx(sent[i], v.rdy_mode != 0 && v.rdy_mode != 2);

    guard = 0;
    while (done_cnt == d0 && guard < 3000) begin guard++; @(negedge clk); end
    repeat (5) @(negedge clk);

    check({tag, "_done_cnt"}, done_cnt - d0, 1);
    check({tag, "_writes"}, got_addr.size(), v.exp_writes);
    nchk = (got_addr.size() < exp_w.size()) ? got_addr.size() : exp_w.size();
    for (int i = 0; i < nchk; i++) begin
      check($sformatf("%s_addr%0d", tag, i), got_addr[i], (v.base + i) % (1 << AW));
      check($sformatf("%s_dat%0d", tag, i), got_dat[i], exp_w[i]);
    end
    if (v.exp_gap != 0) check({tag, "_done_gap"}, done_cyc - last_wr_cyc, v.exp_gap);
    check({tag, "_proto"}, proto_err, 0);
    check({tag, "_inrdy"}, inrdy_err, 0);
    check({tag, "_cfg_rdy"}, cfg_rdy, 1);
  endtask

  vec_t vecs[9];

  initial begin
    int d0;
    vecs[0] = '{5,  5,  'h010, 0, 0,  1, 1};
    vecs[1] = '{3,  4,  'h020, 0, 0,  1, 1};
    vecs[3] = '{0,  4,  'h040, 0, 0,  0, 0};
    vecs[6] = '{1,  0,  'h080, 0, 0,  0, 0};
    vecs[8] = '{2,  4,  'h060, 0, 0,  1, 1};
`ifdef KNN_IDX_PACK_SELF_EXCL_EN
    vecs[2] = '{4,  13, 'h030, 2, 10, 2, 1};
    vecs[4] = '{7,  8,  'h3FF, 1, 0,  2, 0};
    vecs[5] = '{10, 31, 'h100, 3, 0,  12, 0};
    vecs[7] = '{25, 1,  'h200, 1, 0,  0, 0};
`else
    vecs[2] = '{4,  13, 'h030, 2, 10, 3, 1};
    vecs[4] = '{7,  8,  'h3FF, 1, 0,  3, 0};
    vecs[5] = '{10, 31, 'h100, 3, 0,  13, 0};
    vecs[7] = '{25, 1,  'h200, 1, 0,  1, 0};
`endif

    rst_n = 1'b0; clr = 1'b0; cfg_vld = 1'b0; cfg_nop = '0; cfg_k = '0; cfg_base = '0;
    in_idx = '0; in_vld = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cfg_rdy", cfg_rdy, 1);
    check("rst_in_rdy", in_rdy, 0);
    check("rst_wr_vld", wr_vld, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_dat", wr_dat, 0);
    check("rst_done", done, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // clr wins over a simultaneous config handshake.
    @(posedge clk);
    #1;
    cfg_nop = 4; cfg_k = 13; cfg_base = 'h55; cfg_vld = 1'b1; clr = 1'b1;
    @(posedge clk);
    #1;
    cfg_vld = 1'b0; clr = 1'b0;
    @(negedge clk);
    check("clr_vs_cfg_cfg_rdy", cfg_rdy, 1);
    check("clr_vs_cfg_in_rdy", in_rdy, 0);

    // Abort a job after 7 accepted indices.
    @(posedge clk);
    #1;
    got_addr.delete(); got_dat.delete();
    rdy_mode = 0;
    d0 = done_cnt;
    do_cfg(4, 13, 'h50);
    for (int i = 0; i < 7; i++) send_idx(IW'(i + 100), 1'b0);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    @(negedge clk);
    check("clr_cfg_rdy", cfg_rdy, 1);
    check("clr_wr_vld", wr_vld, 0);
    check("clr_wr_addr", wr_addr, 0);
    check("clr_in_rdy", in_rdy, 0);
    repeat (20) @(negedge clk);
    check("clr_no_done", done_cnt - d0, 0);
    check("clr_no_write", got_addr.size(), 0);

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
